// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage: PC register, next-PC logic, instruction-memory
//   request port, DEPTH-entry prefetch queue and IF/ID pipeline register.
//   Handles decode stalls, branch/jump redirect with flush, memory wait-states
//   and a same-cycle bypass from memory to IF/ID when the queue is empty.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   imem_req     fetch request valid
//   imem_addr    fetch address (same as fetch_pc)
//   imem_ready   memory accepts request; imem_rdata valid in the same cycle
//   imem_rdata   instruction word
//   redirect     load redirect_pc and flush queue / IF/ID
//   redirect_pc  new fetch address
//   id_stall     decode cannot accept; IF/ID holds
//   id_valid     IF/ID holds a real instruction
//   id_pc        PC of the IF/ID instruction
//   id_ir        IF/ID instruction word
//   fetch_pc     current fetch PC
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_ir,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic {BOOT, RUN} fetchState_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ir;
    } fetchEntry_t;

    fetchState_e       state;
    logic [ADDR_W-1:0] fetchPc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    fetchEntry_t       qMem [DEPTH];

    fetchEntry_t       headEntry;
    logic              accept;
    logic              qEmpty;
    logic              pop;
    logic              bypass;
    logic              push;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Request depends only on registered state, never on id_stall/imem_ready;
    // a full queue that pops this cycle still suppresses the request.
    assign imem_req  = (state == RUN) && (count < FULL);
    assign imem_addr = fetchPc;
    assign fetch_pc  = fetchPc;

    assign headEntry = qMem[rdPtr];
    assign qEmpty    = (count == '0);
    assign accept    = imem_req && imem_ready && !redirect;
    assign pop       = !redirect && !id_stall && !qEmpty;
    // Bypass keeps FIFO order: only legal when nothing older is queued.
    assign bypass    = accept && !id_stall && qEmpty;
    assign push      = accept && !bypass;

    // Queue storage needs no reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            qMem[wrPtr] <= '{pc: fetchPc, ir: imem_rdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            fetchPc  <= RESET_PC;
            count    <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_ir    <= '0;
        end else begin
            // BOOT lasts exactly one edge, redirect or not.
            state <= RUN;

            if (redirect) begin
                // Flush wins over stall, accept and pop; the response in
                // this cycle is dropped.
                fetchPc  <= redirect_pc;
                count    <= '0;
                rdPtr    <= '0;
                wrPtr    <= '0;
                id_valid <= 1'b0;
            end else begin
                if (accept) begin
                    fetchPc <= fetchPc + STEP;
                end
                if (push) begin
                    wrPtr <= nextPtr(wrPtr);
                end
                if (pop) begin
                    rdPtr <= nextPtr(rdPtr);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase

                if (!id_stall) begin
                    if (!qEmpty) begin
                        id_valid <= 1'b1;
                        id_pc    <= headEntry.pc;
                        id_ir    <= headEntry.ir;
                    end else if (accept) begin
                        id_valid <= 1'b1;
                        id_pc    <= fetchPc;
                        id_ir    <= imem_rdata;
                    end else begin
                        // Bubble: pc/ir keep their last values.
                        id_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit (default parameters). A combinational memory model
//   returns a scrambled word per address. Expected instruction PCs are queued
//   from the known program flow (reset / redirect target, then sequential) and
//   compared as each new instruction appears in IF/ID; directed checks cover
//   reset, stall, redirect, wait-states, wrap and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [15:0] id_ir;
    logic [15:0] fetch_pc;

    int checks = 0;
    int errs   = 0;

    logic [15:0] expQ [$];
    logic [15:0] genPc = RESET_PC;
    logic        lastStall = 1'b1;
    logic        lastRedir = 1'b0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_stall    (id_stall),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_ir       (id_ir),
        .fetch_pc    (fetch_pc)
    );

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5AC3;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sample mid-cycle; an instruction is new when the previous
    // edge loaded IF/ID (no stall, no redirect) and it is valid.
    always begin
        @(negedge clk or negedge rst);
        if (!rst) begin
            expQ.delete();
            genPc     = RESET_PC;
            lastStall = 1'b1;
            lastRedir = 1'b0;
        end else begin
            if (lastRedir) begin
                chk("sb_flush_bubble", 32'(id_valid), 32'd0);
            end else if (!lastStall && id_valid) begin
                if (expQ.size() == 0) begin
                    for (int i = 0; i < 8; i++) begin
                        expQ.push_back(genPc);
                        genPc = genPc + 16'd1;
                    end
                end
                begin
                    logic [15:0] e;
                    e = expQ.pop_front();
                    chk("sb_pc", 32'(id_pc), 32'(e));
                    chk("sb_ir", 32'(id_ir), 32'(memWord(e)));
                end
            end
            lastStall = id_stall;
            lastRedir = redirect;
            if (redirect) begin
                expQ.delete();
                genPc = redirect_pc;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        imem_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        id_stall    = 1'b0;

        // reset state
        #2;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc",    32'(id_pc),    32'd0);
        chk("rst_id_ir",    32'(id_ir),    32'd0);
        chk("rst_fetch_pc", 32'(fetch_pc), 32'(RESET_PC));
        chk("rst_req",      32'(imem_req), 32'd0);
        tick();
        rst = 1'b1;

        // 1: boot and straight-line fetch
        chk("boot_req", 32'(imem_req), 32'd0);
        tick();
        chk("run_req",   32'(imem_req),  32'd1);
        chk("run_addr0", 32'(imem_addr), 32'd0);
        chk("run_idv0",  32'(id_valid),  32'd0);
        tick();
        chk("first_idv",  32'(id_valid),  32'd1);
        chk("first_idpc", 32'(id_pc),     32'd0);
        chk("first_addr", 32'(imem_addr), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_idv",  32'(id_valid), 32'd1);
            chk("seq_idpc", 32'(id_pc),    32'(i));
        end

        // 2: stall 4 cycles fills the queue and drops the request
        id_stall = 1'b1;
        tick();
        chk("stall_hold_pc", 32'(id_pc), 32'd5);
        tick();
        chk("stall_full_req", 32'(imem_req), 32'd0);
        tick();
        tick();
        chk("stall_hold_idv", 32'(id_valid),  32'd1);
        chk("stall_hold_pc2", 32'(id_pc),     32'd5);
        chk("stall_hold_ir",  32'(id_ir),     32'(memWord(16'd5)));
        chk("stall_req_low",  32'(imem_req),  32'd0);
        chk("stall_addr",     32'(imem_addr), 32'd8);
        id_stall = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            tick();
            chk("drain_idv",  32'(id_valid), 32'd1);
            chk("drain_idpc", 32'(id_pc),    32'(i));
        end

        // 3: redirect with full queue and stall asserted
        id_stall = 1'b1;
        tick();
        tick();
        chk("redir_full_req", 32'(imem_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        chk("redir_idv",   32'(id_valid),  32'd0);
        chk("redir_addr",  32'(imem_addr), 32'h40);
        chk("redir_fpc",   32'(fetch_pc),  32'h40);
        chk("redir_req",   32'(imem_req),  32'd1);
        redirect = 1'b0;
        id_stall = 1'b0;
        tick();
        chk("redir_tgt_idv",  32'(id_valid),  32'd1);
        chk("redir_tgt_idpc", 32'(id_pc),     32'h40);
        chk("redir_tgt_addr", 32'(imem_addr), 32'h41);

        // 4: memory wait-states
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr", 32'(imem_addr), 32'h41);
            chk("wait_idv",  32'(id_valid),  32'd0);
            chk("wait_req",  32'(imem_req),  32'd1);
        end
        imem_ready = 1'b1;
        tick();
        chk("resume_idv",  32'(id_valid), 32'd1);
        chk("resume_idpc", 32'(id_pc),    32'h41);
        tick();
        chk("resume_idpc2", 32'(id_pc), 32'h42);

        // 5: PC wraps at 0xFFFF
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        chk("wrap_idv",  32'(id_valid),  32'd0);
        chk("wrap_addr", 32'(imem_addr), 32'hFFFF);
        redirect = 1'b0;
        tick();
        chk("wrap_pc0", 32'(id_pc), 32'hFFFF);
        tick();
        chk("wrap_pc1", 32'(id_pc),     32'h0000);
        chk("wrap_fpc", 32'(fetch_pc),  32'h0001);
        tick();
        chk("wrap_pc2", 32'(id_pc), 32'h0001);

        // 6: asynchronous reset pulse between edges
        rst = 1'b0;
        #2;
        chk("arst_idv",  32'(id_valid), 32'd0);
        chk("arst_idpc", 32'(id_pc),    32'd0);
        chk("arst_fpc",  32'(fetch_pc), 32'(RESET_PC));
        chk("arst_req",  32'(imem_req), 32'd0);
        rst = 1'b1;
        chk("rboot_req", 32'(imem_req), 32'd0);
        tick();
        chk("rrun_req",  32'(imem_req),  32'd1);
        chk("rrun_addr", 32'(imem_addr), 32'd0);
        tick();
        chk("rfirst_idv",  32'(id_valid), 32'd1);
        chk("rfirst_idpc", 32'(id_pc),    32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rseq_idpc", 32'(id_pc), 32'(i));
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
